alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width in bits, legal range 16..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand rs.
REQ-007 SHALL have port b  input  WIDTH  operand rt.
REQ-008 SHALL have port instruction  input  32  MIPS-encoded instruction; [31:26] opcode, [10:6] shamt, [5:0] funct, [15:0] imm.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  primary result; LO for mult/div.
REQ-012 SHALL have port hi  output  WIDTH  HI for mult/div; 0 for all other ops.
REQ-013 SHALL have port ovf  output  1  signed overflow on add, sub or addi.
REQ-014 SHALL have port dz  output  1  divide by zero.
REQ-015 SHALL have port illegal  output  1  undecoded opcode/funct.

Function
REQ-016 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, capturing a, b and instruction.
REQ-017 SHALL implement a state machine IDLE -> EXEC -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-018 SHALL decode these R-type ops (opcode 000000), by funct:
- add 100000, addu 100001, sub 100010, subu 100011
- and 100100, or 100101, slt 101010
- sll 000000, srl 000010
- mult 011000, multu 011001, div 011010, divu 011011
REQ-019 SHALL decode these I-type ops, by opcode: addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101.
REQ-020 SHALL sign-extend imm to WIDTH for addi, addiu and slti, and zero-extend it for andi and ori.
REQ-021 SHALL apply sll/srl to b by shamt, with zero fill.
REQ-022 SHALL make slt/slti a signed compare, with result 1 or 0 zero-extended.
REQ-023 SHALL wrap all sums modulo 2^WIDTH; ovf = 1 only for add, sub and addi on signed overflow, with the wrapped result still written.
REQ-024 SHALL complete single-cycle ops in one EXEC cycle: out_valid rises 2 edges after acceptance.
REQ-025 SHALL compute mult/multu iteratively, one bit per cycle, over WIDTH EXEC cycles: {hi,result} = full 2*WIDTH product, signed for mult.
REQ-026 SHALL compute div/divu iteratively with restoring division over WIDTH EXEC cycles: result = quotient, hi = remainder, truncating toward zero, remainder taking the sign of a for div.
REQ-027 SHALL handle b = 0 on div/divu in one EXEC cycle: result = all ones, hi = a, dz = 1.
REQ-028 SHALL handle signed div of most-negative by -1 as: result = most-negative, hi = 0, ovf = 0.
REQ-029 SHALL handle an illegal instruction in one EXEC cycle: result = 0, hi = 0, illegal = 1.
REQ-030 SHALL in DONE hold out_valid = 1 and all outputs stable until out_ready = 1, then return to IDLE on that edge with out_valid = 0.
REQ-031 SHALL ignore in_valid while not in IDLE; there is no request queuing.
REQ-032 SHALL hold result, hi, ovf, dz and illegal at their last values while out_valid = 0, and ignore out_ready while out_valid = 0.

Reset
REQ-033 SHALL on rst = 1 at a rising edge: go to IDLE and clear out_valid, result, hi, ovf, dz, illegal and the iteration counter; in_ready = 1 from the next cycle.
REQ-034 SHALL give rst priority over all other inputs, aborting any in-flight EXEC or DONE with no result delivered.

Verification
REQ-035 SHALL cover WIDTH=32, a=10, b=5, add -> result 15, ovf 0, out_valid 2 cycles after accept; then sub -> 5; and a=1, b=2 -> 0 (and), 3 (or), 1 (slt).
REQ-036 SHALL cover a=0x7FFFFFFF, b=1: add -> result 0x80000000, ovf 1; addu -> the same result, ovf 0.
REQ-037 SHALL cover a=-3, b=5, mult with out_ready held 0 for 5 cycles -> result 0xFFFFFFF1, hi 0xFFFFFFFF, valid 33 cycles after accept, outputs stable while stalled, in_ready 0 throughout.
REQ-038 SHALL cover div and divu with a=7, b=0 -> result 0xFFFFFFFF, hi 7, dz 1; div with a=-7, b=2 -> result -3, hi -1.
REQ-039 SHALL cover a=1, b=2, imm 0xFFFF: addi -> 0, andi -> 1, ori -> 0xFFFF, slti -> 0; sll shamt 2 -> 8; srl shamt 2 -> 0.
REQ-040 SHALL cover rst asserted mid-mult at cycle 10 -> out_valid 0 and all outputs 0 next cycle, in_ready 1, no stale result delivered; then an undecoded funct 111111 -> illegal 1, result 0.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS-style ALU with a valid/ready handshake.
// Single-cycle ops finish after one EXEC cycle. mult/div iterate one bit per
// cycle on operand magnitudes. The sign is applied once, when the op finishes.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             ovf,
  output logic             dz,
  output logic             illegal
);

  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDU  = 5'd1,  OP_SUB   = 5'd2,  OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_OR    = 5'd5,  OP_SLT   = 5'd6,  OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8,  OP_MULT  = 5'd9,  OP_MULTU = 5'd10, OP_DIV   = 5'd11;
  localparam logic [4:0] OP_DIVU = 5'd12, OP_ADDI  = 5'd13, OP_ADDIU = 5'd14, OP_SLTI  = 5'd15;
  localparam logic [4:0] OP_ANDI = 5'd16, OP_ORI   = 5'd17, OP_ILL   = 5'd31;

  // Map opcode/funct to an internal op id; anything unlisted is illegal.
  function automatic logic [4:0] decode_op(input logic [31:0] ins);
    logic [4:0] op;
    op = OP_ILL;
    case (ins[31:26])
      6'b000000: begin
        case (ins[5:0])
          6'b100000: op = OP_ADD;
          6'b100001: op = OP_ADDU;
          6'b100010: op = OP_SUB;
          6'b100011: op = OP_SUBU;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b000000: op = OP_SLL;
          6'b000010: op = OP_SRL;
          6'b011000: op = OP_MULT;
          6'b011001: op = OP_MULTU;
          6'b011010: op = OP_DIV;
          6'b011011: op = OP_DIVU;
          default:   op = OP_ILL;
        endcase
      end
      6'b001000: op = OP_ADDI;
      6'b001001: op = OP_ADDIU;
      6'b001010: op = OP_SLTI;
      6'b001100: op = OP_ANDI;
      6'b001101: op = OP_ORI;
      default:   op = OP_ILL;
    endcase
    return op;
  endfunction

  logic [1:0]       state_r;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, mag_r, acc_hi_r, acc_lo_r;
  logic [15:0]      imm_r;
  logic [4:0]       shamt_r;
  logic             neg_q_r, neg_r_r;
  logic [CW-1:0]    cnt_r;
  logic             out_valid_r, ovf_r, dz_r, illegal_r;
  logic [WIDTH-1:0] result_r, hi_r;

  assign in_ready  = (state_r == S_IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign hi        = hi_r;
  assign ovf       = ovf_r;
  assign dz        = dz_r;
  assign illegal   = illegal_r;

  // Accept side: decode the incoming op and form operand magnitudes for mult/div.
  logic [4:0]       in_op_s;
  logic             in_signed_s, a_neg_s, b_neg_s, in_div_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  always_comb begin
    in_op_s     = decode_op(instruction);
    in_signed_s = (in_op_s == OP_MULT) || (in_op_s == OP_DIV);
    in_div_s    = (in_op_s == OP_DIV) || (in_op_s == OP_DIVU);
    a_neg_s     = in_signed_s & a[WIDTH-1];
    b_neg_s     = in_signed_s & b[WIDTH-1];
    abs_a_s     = a_neg_s ? (-a) : a;
    abs_b_s     = b_neg_s ? (-b) : b;
  end

  // Execute side: single-cycle results, one mult/div iteration and final sign fix-up.
  logic [WIDTH-1:0]   imm_sx_s, imm_zx_s, sum_ab_s, dif_ab_s, sum_ai_s, add_s;
  logic [WIDTH-1:0]   res_s, hi_s, acc_hi_n_s, acc_lo_n_s;
  logic [WIDTH:0]     msum_s, dshift_s, ddiff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               ovf_s, dz_s, ill_s, is_mul_s, is_div_s, div_zero_s, long_s;
  always_comb begin
    imm_sx_s   = {{(WIDTH-16){imm_r[15]}}, imm_r};
    imm_zx_s   = {{(WIDTH-16){1'b0}}, imm_r};
    sum_ab_s   = a_r + b_r;
    dif_ab_s   = a_r - b_r;
    sum_ai_s   = a_r + imm_sx_s;
    res_s      = '0;
    hi_s       = '0;
    ovf_s      = 1'b0;
    dz_s       = 1'b0;
    ill_s      = 1'b0;
    is_mul_s   = (op_r == OP_MULT) || (op_r == OP_MULTU);
    is_div_s   = (op_r == OP_DIV) || (op_r == OP_DIVU);
    div_zero_s = is_div_s && (b_r == '0);
    long_s     = is_mul_s || (is_div_s && !div_zero_s);
    case (op_r)
      OP_ADD: begin
        res_s = sum_ab_s;
        ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_ab_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_ADDU: res_s = sum_ab_s;
      OP_SUB: begin
        res_s = dif_ab_s;
        ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (dif_ab_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUBU:  res_s = dif_ab_s;
      OP_AND:   res_s = a_r & b_r;
      OP_OR:    res_s = a_r | b_r;
      OP_SLT:   res_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SLL:   res_s = b_r << shamt_r;
      OP_SRL:   res_s = b_r >> shamt_r;
      OP_ADDI: begin
        res_s = sum_ai_s;
        ovf_s = (a_r[WIDTH-1] == imm_sx_s[WIDTH-1]) && (sum_ai_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_ADDIU: res_s = sum_ai_s;
      OP_SLTI:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(imm_sx_s))};
      OP_ANDI:  res_s = a_r & imm_zx_s;
      OP_ORI:   res_s = a_r | imm_zx_s;
      OP_DIV, OP_DIVU: begin
        // Only reaches the single-cycle path when the divisor is zero.
        res_s = '1;
        hi_s  = a_r;
        dz_s  = 1'b1;
      end
      OP_MULT, OP_MULTU: res_s = '0;
      default: ill_s = 1'b1;
    endcase

    // Shift-add multiply step: acc_lo holds the multiplier and fills with product bits.
    add_s    = acc_lo_r[0] ? mag_r : '0;
    msum_s   = {1'b0, acc_hi_r} + {1'b0, add_s};
    // Restoring divide step: acc_hi is the partial remainder, acc_lo the quotient.
    dshift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    ddiff_s  = dshift_s - {1'b0, mag_r};
    if (is_mul_s) begin
      acc_hi_n_s = msum_s[WIDTH:1];
      acc_lo_n_s = {msum_s[0], acc_lo_r[WIDTH-1:1]};
    end else if (!ddiff_s[WIDTH]) begin
      acc_hi_n_s = ddiff_s[WIDTH-1:0];
      acc_lo_n_s = {acc_lo_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_hi_n_s = dshift_s[WIDTH-1:0];
      acc_lo_n_s = {acc_lo_r[WIDTH-2:0], 1'b0};
    end
    prod_s = {acc_hi_n_s, acc_lo_n_s};
    if (neg_q_r) begin
      prod_s = -prod_s;
    end else begin
      prod_s = prod_s;
    end
  end

  // Control FSM, operand capture, iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      op_r        <= OP_ILL;
      a_r         <= '0;
      b_r         <= '0;
      mag_r       <= '0;
      acc_hi_r    <= '0;
      acc_lo_r    <= '0;
      imm_r       <= 16'd0;
      shamt_r     <= 5'd0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      hi_r        <= '0;
      ovf_r       <= 1'b0;
      dz_r        <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            state_r  <= S_EXEC;
            op_r     <= in_op_s;
            a_r      <= a;
            b_r      <= b;
            imm_r    <= instruction[15:0];
            shamt_r  <= instruction[10:6];
            mag_r    <= in_div_s ? abs_b_s : abs_a_s;
            acc_hi_r <= '0;
            acc_lo_r <= in_div_s ? abs_a_s : abs_b_s;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            cnt_r    <= '0;
          end
        end
        S_EXEC: begin
          if (long_s) begin
            acc_hi_r <= acc_hi_n_s;
            acc_lo_r <= acc_lo_n_s;
            cnt_r    <= cnt_r + 1'b1;
            if (cnt_r == LAST) begin
              state_r     <= S_DONE;
              out_valid_r <= 1'b1;
              ovf_r       <= 1'b0;
              dz_r        <= 1'b0;
              illegal_r   <= 1'b0;
              if (is_mul_s) begin
                result_r <= prod_s[WIDTH-1:0];
                hi_r     <= prod_s[2*WIDTH-1:WIDTH];
              end else begin
                result_r <= neg_q_r ? (-acc_lo_n_s) : acc_lo_n_s;
                hi_r     <= neg_r_r ? (-acc_hi_n_s) : acc_hi_n_s;
              end
            end
          end else begin
            state_r     <= S_DONE;
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            hi_r        <= hi_s;
            ovf_r       <= ovf_s;
            dz_r        <= dz_s;
            illegal_r   <= ill_s;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
